// File: rtl/alien_bullet.sv
// rtl/alien_bullet.sv - alien projectile: launch, one-row fall per step tick, player hit test, erase/draw pixel stream
module alien_bullet #(
    parameter int       STEP_DIV  = 833333,
    parameter int       BULLET_H  = 2,
    parameter int       ALIEN_H   = 4,
    parameter int       PLAYER_SZ = 4,
    parameter int       Y_BOTTOM  = 119,
    parameter bit [2:0] B_COLOUR  = 3'b100
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       fire,
    input  logic [7:0] alien_x,
    input  logic [6:0] alien_y,
    input  logic [7:0] player_x,
    input  logic [6:0] player_y,
    input  logic       clear_hit,
    output logic       busy,
    output logic       got_hit,
    output logic [7:0] x_pos,
    output logic [6:0] y_pos,
    output logic [2:0] colour,
    output logic       plot
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_DRAW  = 3'd1;
    localparam logic [2:0] S_CHECK = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_ERASE = 3'd4;
    localparam logic [2:0] S_MOVE  = 3'd5;

    localparam int CW = $clog2(STEP_DIV);
    localparam int IW = $clog2(BULLET_H + 1);

    logic [2:0]    state, state_next;
    logic [7:0]    bx, by;
    logic [CW-1:0] counter;
    logic [IW-1:0] idx;
    logic          term;

    logic [7:0] launch_row;
    logic [8:0] bx9, by9, px9, py9, launch9;
    logic       launch_ok, x_ok, y_ok, hit, at_bottom, last_row;

    // All geometry is compared in 9 bits so boxes touching the screen edge never wrap.
    assign launch_row = {1'b0, alien_y} + 8'(ALIEN_H);
    assign launch9    = {1'b0, launch_row};
    assign launch_ok  = (launch9 + 9'(BULLET_H - 1)) <= 9'(Y_BOTTOM);
    assign bx9        = {1'b0, bx};
    assign by9        = {1'b0, by};
    assign px9        = {1'b0, player_x};
    assign py9        = {2'b00, player_y};
    assign x_ok       = (px9 <= bx9) && (bx9 <= px9 + 9'(PLAYER_SZ - 1));
    assign y_ok       = (by9 <= py9 + 9'(PLAYER_SZ - 1)) && (by9 + 9'(BULLET_H - 1) >= py9);
    assign hit        = x_ok && y_ok;
    assign at_bottom  = (by9 + 9'(BULLET_H - 1)) == 9'(Y_BOTTOM);
    assign last_row   = idx == IW'(BULLET_H - 1);

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (fire && launch_ok) state_next = S_DRAW;
            S_DRAW:  if (last_row) state_next = S_CHECK;
            S_CHECK: state_next = (hit || at_bottom) ? S_ERASE : S_WAIT;
            S_WAIT:  if (counter == '0) state_next = S_ERASE;
            S_ERASE: if (last_row) state_next = term ? S_IDLE : S_MOVE;
            S_MOVE:  state_next = S_DRAW;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= S_IDLE;
            bx      <= '0;
            by      <= '0;
            counter <= '0;
            idx     <= '0;
            term    <= 1'b0;
            busy    <= 1'b0;
            got_hit <= 1'b0;
            x_pos   <= '0;
            y_pos   <= '0;
            colour  <= '0;
            plot    <= 1'b0;
        end else begin
            state  <= state_next;
            busy   <= state_next != S_IDLE;
            plot   <= 1'b0;
            x_pos  <= '0;
            y_pos  <= '0;
            colour <= '0;
            // Clear first so a hit found in CHECK this cycle overrides it.
            if (clear_hit) got_hit <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (fire && launch_ok) begin
                        bx  <= alien_x;
                        by  <= launch_row;
                        idx <= '0;
                    end
                end
                S_DRAW, S_ERASE: begin
                    plot   <= 1'b1;
                    x_pos  <= bx;
                    y_pos  <= 7'(by + 8'(idx));
                    colour <= (state == S_DRAW) ? B_COLOUR : 3'b000;
                    idx    <= last_row ? '0 : idx + 1'b1;
                    if (state == S_ERASE && last_row && term) term <= 1'b0;
                end
                S_CHECK: begin
                    if (hit) begin
                        got_hit <= 1'b1;
                        term    <= 1'b1;
                    end else if (at_bottom) begin
                        term <= 1'b1;
                    end else begin
                        counter <= CW'(STEP_DIV - 1);
                    end
                end
                S_WAIT:  counter <= counter - 1'b1;
                S_MOVE:  by <= by + 8'd1;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_alien_bullet.sv
// tb/tb_alien_bullet.sv - table-driven bench for alien_bullet with hand-written corner sequences
module tb_alien_bullet;
    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       fire = 1'b0;
    logic [7:0] alien_x = '0;
    logic [6:0] alien_y = '0;
    logic [7:0] player_x = '0;
    logic [6:0] player_y = '0;
    logic       clear_hit = 1'b0;
    logic       busy, got_hit, plot;
    logic [7:0] x_pos;
    logic [6:0] y_pos;
    logic [2:0] colour;

    alien_bullet #(.STEP_DIV(4)) dut (
        .clk(clk), .reset_n(reset_n), .fire(fire), .alien_x(alien_x), .alien_y(alien_y),
        .player_x(player_x), .player_y(player_y), .clear_hit(clear_hit), .busy(busy),
        .got_hit(got_hit), .x_pos(x_pos), .y_pos(y_pos), .colour(colour), .plot(plot)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] ax;
        logic [6:0] ay;
        logic [7:0] px;
        logic [6:0] py;
        int         exp_hit;
        int         exp_final;
        int         exp_pix;
    } vec_t;

    vec_t vecs[10];
    int   errors = 0;
    int   checks = 0;

    int n_pix, first_cyc, first_x, first_y, first_c, last_x, last_y, last_c, bad_x, hit_at_clr;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Fire once, then sample every negedge until busy drops, optionally pulsing fire/clear_hit mid-flight.
    task automatic fly(input logic [7:0] ax, input logic [6:0] ay, input logic [7:0] px,
                       input logic [6:0] py, input int fire_at, input int clr_at);
        bit done = 0;
        n_pix = 0; first_cyc = -1; bad_x = 0; hit_at_clr = -1;
        first_x = 0; first_y = 0; first_c = 0; last_x = 0; last_y = 0; last_c = 0;
        alien_x = ax; alien_y = ay; player_x = px; player_y = py; fire = 1'b1;
        @(posedge clk);
        for (int k = 0; k < 3000 && !done; k++) begin
            @(negedge clk);
            if (plot) begin
                if (first_cyc < 0) begin
                    first_cyc = k; first_x = x_pos; first_y = y_pos; first_c = colour;
                end
                last_x = x_pos; last_y = y_pos; last_c = colour;
                if (x_pos != ax) bad_x++;
                n_pix++;
            end
            if (k == clr_at + 1) hit_at_clr = got_hit;
            fire      = (k == fire_at);
            alien_x   = (k == fire_at) ? 8'd200 : ax;
            clear_hit = (k == clr_at);
            if (!busy) done = 1;
        end
        fire = 1'b0; clear_hit = 1'b0; alien_x = ax;
        chk("flight_timeout", done, 1);
    endtask

    task automatic pulse_clear();
        @(negedge clk); clear_hit = 1'b1;
        @(negedge clk); clear_hit = 1'b0;
    endtask

    initial begin
        //            ax   ay   px   py  hit final pix
        vecs[0] = '{8'd40, 7'd10, 8'd78, 7'd100, 0, 118, 420};
        vecs[1] = '{8'd79, 7'd90, 8'd78, 7'd100, 1,  99,  24};
        vecs[2] = '{8'd77, 7'd90, 8'd78, 7'd100, 0, 118, 100};
        vecs[3] = '{8'd82, 7'd90, 8'd78, 7'd100, 0, 118, 100};
        vecs[4] = '{8'd78, 7'd90, 8'd78, 7'd100, 1,  99,  24};
        vecs[5] = '{8'd81, 7'd90, 8'd78, 7'd100, 1,  99,  24};
        vecs[6] = '{8'd79, 7'd100, 8'd78, 7'd100, 0, 118, 60};
        vecs[7] = '{8'd79, 7'd98, 8'd78, 7'd100, 1, 102,   4};
        vecs[8] = '{8'd10, 7'd114, 8'd78, 7'd100, 0, 118,  4};
        vecs[9] = '{8'd79, 7'd100, 8'd78, 7'd118, 1, 117, 56};

        repeat (3) @(negedge clk);
        chk("reset_busy", busy, 0);
        chk("reset_plot", plot, 0);
        chk("reset_got_hit", got_hit, 0);
        chk("reset_xy", {x_pos, y_pos}, 0);
        reset_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            pulse_clear();
            chk($sformatf("v%0d_pre_clear", i), got_hit, 0);
            fly(vecs[i].ax, vecs[i].ay, vecs[i].px, vecs[i].py, (i == 0) ? 20 : -10, -10);
            chk($sformatf("v%0d_got_hit", i), got_hit, vecs[i].exp_hit);
            chk($sformatf("v%0d_pixels", i), n_pix, vecs[i].exp_pix);
            chk($sformatf("v%0d_first_cyc", i), first_cyc, 1);
            chk($sformatf("v%0d_first_xyc", i), {first_x, first_y, first_c},
                {32'(vecs[i].ax), 32'(vecs[i].ay) + 32'd4, 32'd4});
            chk($sformatf("v%0d_last_xyc", i), {last_x, last_y, last_c},
                {32'(vecs[i].ax), vecs[i].exp_final + 1, 32'd0});
            chk($sformatf("v%0d_bad_x", i), bad_x, 0);
            repeat (3) @(negedge clk);
            chk($sformatf("v%0d_idle_after", i), busy, 0);
        end

        // got_hit is set from the last vector; clear_hit drops it next edge.
        chk("hit_before_clear", got_hit, 1);
        clear_hit = 1'b1;
        @(negedge clk);
        clear_hit = 1'b0;
        chk("clear_hit", got_hit, 0);

        // Launch would put the bullet below the screen: fire is dropped.
        alien_x = 8'd50; alien_y = 7'd117; fire = 1'b1;
        @(negedge clk);
        fire = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("drop_busy", busy, 0);
            chk("drop_plot", plot, 0);
            @(negedge clk);
        end

        // clear_hit during the CHECK that hits: set wins.
        fly(8'd79, 7'd98, 8'd78, 7'd100, -10, 2);
        chk("set_wins_at_check", hit_at_clr, 1);
        chk("set_wins_end", got_hit, 1);

        // Reset during WAIT kills the bullet with no erase.
        alien_x = 8'd40; alien_y = 7'd10; player_x = 8'd78; player_y = 7'd100; fire = 1'b1;
        @(posedge clk);
        @(negedge clk); fire = 1'b0;
        repeat (4) @(negedge clk);
        chk("pre_reset_busy", busy, 1);
        reset_n = 1'b0;
        #1;
        chk("async_busy", busy, 0);
        chk("async_plot", plot, 0);
        chk("async_got_hit", got_hit, 0);
        chk("async_pixel", {x_pos, y_pos, colour}, 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        fly(8'd40, 7'd10, 8'd78, 7'd100, -10, -10);
        chk("relaunch_pixels", n_pix, 420);
        chk("relaunch_first", {first_x, first_y, first_c}, {32'd40, 32'd14, 32'd4});
        chk("relaunch_first_cyc", first_cyc, 1);
        chk("relaunch_hit", got_hit, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
